// File: rtl/sbox_share_ctrl_if.sv
// rtl/sbox_share_ctrl_if.sv - request/response bundle between round control and the S-box share controller
// The requester side (round control / key schedule) is the master.
interface sbox_share_ctrl_if;
    logic         st_req_valid;
    logic         st_req_ready;
    logic [127:0] st_req_data;
    logic         st_rsp_valid;
    logic [127:0] st_rsp_data;
    logic         ks_req_valid;
    logic         ks_req_ready;
    logic [31:0]  ks_req_data;
    logic         ks_rsp_valid;
    logic [31:0]  ks_rsp_data;

    modport master (
        output st_req_valid, st_req_data, ks_req_valid, ks_req_data,
        input  st_req_ready, st_rsp_valid, st_rsp_data,
        input  ks_req_ready, ks_rsp_valid, ks_rsp_data
    );

    modport slave (
        input  st_req_valid, st_req_data, ks_req_valid, ks_req_data,
        output st_req_ready, st_rsp_valid, st_rsp_data,
        output ks_req_ready, ks_rsp_valid, ks_rsp_data
    );
endinterface

// File: rtl/sbox_share_ctrl.sv
// rtl/sbox_share_ctrl.sv - arbitrates SubBytes/SubWord jobs onto a shared LANES-wide S-box lookup
// Jobs are sliced into beats of LANES bytes; results are merged into a work buffer.
module sbox_share_ctrl #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    sbox_share_ctrl_if.slave     bus,
    output logic                 sb_en,
    output logic [8*LANES-1:0]   sb_in,
    input  logic [8*LANES-1:0]   sb_out,
    output logic                 busy
);

    localparam int N_ST = 16 / LANES;
    localparam int N_KS = (LANES >= 4) ? 1 : 4 / LANES;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN_ST  = 3'd1;
    localparam logic [2:0] S_RUN_KS  = 3'd2;
    localparam logic [2:0] S_RESP_ST = 3'd3;
    localparam logic [2:0] S_RESP_KS = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [3:0]   beat_q, beat_d;
    logic         last_grant_q, last_grant_d;   // 1 = key schedule
    logic [127:0] job_q, job_d;
    logic [127:0] work_q, work_d;
    logic [127:0] st_out_q, st_out_d;
    logic [31:0]  ks_out_q, ks_out_d;

    logic idle, run_st, run_ks, last_beat;
    logic st_ready, ks_ready;

    assign idle   = (state_q == S_IDLE);
    assign run_st = (state_q == S_RUN_ST);
    assign run_ks = (state_q == S_RUN_KS);
    assign last_beat = run_st ? (beat_q == 4'(N_ST - 1)) : (beat_q == 4'(N_KS - 1));

    // Gated by resetn so the readys also read 0 while reset is held.
    assign st_ready = resetn & idle & bus.st_req_valid & (~bus.ks_req_valid | last_grant_q);
    assign ks_ready = resetn & idle & bus.ks_req_valid & (~bus.st_req_valid | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        last_grant_d = last_grant_q;
        job_d        = job_q;
        work_d       = work_q;
        st_out_d     = st_out_q;
        ks_out_d     = ks_out_q;
        sb_in        = '0;

        // Key-schedule words only fill lanes 0..3; wider lanes stay at 0x00.
        for (int l = 0; l < LANES; l++) begin
            if (run_st || (run_ks && l < 4)) begin
                sb_in[8*l +: 8] = job_q[8*(int'(beat_q)*LANES + l) +: 8];
                work_d[8*(int'(beat_q)*LANES + l) +: 8] = sb_out[8*l +: 8];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (st_ready) begin
                    state_d      = S_RUN_ST;
                    job_d        = bus.st_req_data;
                    beat_d       = 4'd0;
                    last_grant_d = 1'b0;
                end else if (ks_ready) begin
                    state_d      = S_RUN_KS;
                    job_d        = {96'd0, bus.ks_req_data};
                    beat_d       = 4'd0;
                    last_grant_d = 1'b1;
                end
            end
            S_RUN_ST: begin
                beat_d = beat_q + 4'd1;
                if (last_beat) begin
                    state_d  = S_RESP_ST;
                    st_out_d = work_d;
                end
            end
            S_RUN_KS: begin
                beat_d = beat_q + 4'd1;
                if (last_beat) begin
                    state_d  = S_RESP_KS;
                    ks_out_d = work_d[31:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            beat_q       <= 4'd0;
            last_grant_q <= 1'b1;
            job_q        <= '0;
            work_q       <= '0;
            st_out_q     <= '0;
            ks_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            job_q        <= job_d;
            work_q       <= work_d;
            st_out_q     <= st_out_d;
            ks_out_q     <= ks_out_d;
        end
    end

    assign bus.st_req_ready = st_ready;
    assign bus.ks_req_ready = ks_ready;
    assign bus.st_rsp_valid = (state_q == S_RESP_ST);
    assign bus.ks_rsp_valid = (state_q == S_RESP_KS);
    assign bus.st_rsp_data  = st_out_q;
    assign bus.ks_rsp_data  = ks_out_q;
    assign sb_en            = run_st | run_ks;
    assign busy             = ~idle;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// tb/tb_sbox_share_ctrl.sv - directed bench for sbox_share_ctrl at LANES = 4, 1, 8, 16
module tb_sbox_share_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]         st_v = '0, ks_v = '0;
    logic [3:0][127:0]  st_d = '0;
    logic [3:0][31:0]   ks_d = '0;
    logic [3:0]         st_r, ks_r, st_rv, ks_rv, sb_en_a, busy_a;
    logic [3:0][127:0]  st_rd, sb_in_a;
    logic [3:0][31:0]   ks_rd;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'd0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Reference S-box: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'd0;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'd1) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic int lanes_of(input int d);
        case (d)
            0: return 4;
            1: return 1;
            2: return 8;
            default: return 16;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gd
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
        sbox_share_ctrl_if bus ();
        logic [8*L-1:0] sbi, sbo;
        logic sbe, bsy;

        assign bus.st_req_valid = st_v[g];
        assign bus.st_req_data  = st_d[g];
        assign bus.ks_req_valid = ks_v[g];
        assign bus.ks_req_data  = ks_d[g];
        assign st_r[g]  = bus.st_req_ready;
        assign ks_r[g]  = bus.ks_req_ready;
        assign st_rv[g] = bus.st_rsp_valid;
        assign ks_rv[g] = bus.ks_rsp_valid;
        assign st_rd[g] = bus.st_rsp_data;
        assign ks_rd[g] = bus.ks_rsp_data;
        assign sb_en_a[g] = sbe;
        assign sb_in_a[g] = 128'(sbi);
        assign busy_a[g]  = bsy;

        always_comb begin
            sbo = '0;
            for (int l = 0; l < L; l++) sbo[8*l +: 8] = sbox_f(sbi[8*l +: 8]);
        end

        sbox_share_ctrl #(.LANES(L)) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (bus),
            .sb_en  (sbe),
            .sb_in  (sbi),
            .sb_out (sbo),
            .busy   (bsy)
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_job(input int d, input bit ks, input logic [127:0] data,
                           input logic [127:0] exp, input string nm);
        int L, n;
        bit got;
        logic [127:0] ein;
        L = lanes_of(d);
        n = ks ? ((L >= 4) ? 1 : 4 / L) : 16 / L;
        @(posedge clk); #1;
        if (ks) begin ks_v[d] = 1'b1; ks_d[d] = data[31:0]; end
        else    begin st_v[d] = 1'b1; st_d[d] = data;       end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ks ? ks_r[d] : st_r[d];
        end
        chk({nm, " ready"}, 128'(got), 128'd1);
        if (!got) begin st_v[d] = 1'b0; ks_v[d] = 1'b0; return; end
        @(posedge clk); #1;
        // Drop the request, scribble its data, and raise the other requester meanwhile.
        if (ks) begin ks_v[d] = 1'b0; ks_d[d] = '1; st_v[d] = 1'b1; st_d[d] = '1; end
        else    begin st_v[d] = 1'b0; st_d[d] = '1; ks_v[d] = 1'b1; ks_d[d] = '1; end
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            ein = '0;
            for (int l = 0; l < L; l++)
                if (!ks || l < 4) ein[8*l +: 8] = data[8*(b*L + l) +: 8];
            chk($sformatf("%s beat%0d sb_en", nm, b), 128'(sb_en_a[d]), 128'd1);
            chk($sformatf("%s beat%0d sb_in", nm, b), sb_in_a[d], ein);
            chk($sformatf("%s beat%0d readys", nm, b), 128'({st_r[d], ks_r[d]}), 128'd0);
            chk($sformatf("%s beat%0d rsp_valid", nm, b), 128'(ks ? ks_rv[d] : st_rv[d]), 128'd0);
            if (b == n - 1) begin st_v[d] = 1'b0; ks_v[d] = 1'b0; end
        end
        @(negedge clk);
        chk({nm, " rsp_valid"}, 128'(ks ? ks_rv[d] : st_rv[d]), 128'd1);
        chk({nm, " rsp_data"}, ks ? 128'(ks_rd[d]) : st_rd[d], exp);
        chk({nm, " resp sb_en/sb_in"}, 128'(sb_en_a[d]) | sb_in_a[d], 128'd0);
        @(negedge clk);
        chk({nm, " rsp pulse end"}, 128'({st_rv[d], ks_rv[d], busy_a[d]}), 128'd0);
        chk({nm, " rsp hold"}, ks ? 128'(ks_rd[d]) : st_rd[d], exp);
    endtask

    typedef struct {
        bit           ks;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] rdata, rexp;
        bit   got, seen, winner;

        vt[0] = '{1'b0, 128'h0, {16{8'h63}}};
        vt[1] = '{1'b1, 128'hff530100, 128'h16ed7c63};
        vt[2] = '{1'b0, 128'h0f0e0d0c_0b0a0908_07060504_03020100,
                        128'h76abd7fe_2b670130_c56f6bf2_7b777c63};
        vt[3] = '{1'b1, 128'h30201000, 128'h04b7ca63};
        vt[4] = '{1'b0, 128'hf0e0d0c0_b0a09080_70605040_30201000,
                        128'h8ce170ba_e7e060cd_51d05309_04b7ca63};
        vt[5] = '{1'b1, 128'h03020100, 128'h7b777c63};

        // Both requesters valid while in reset; the tie sequence follows.
        st_v[0] = 1'b1; st_d[0] = '0;
        ks_v[0] = 1'b1; ks_d[0] = 32'hff530100;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset dut%0d ctl", d),
                128'({st_r[d], ks_r[d], st_rv[d], ks_rv[d], sb_en_a[d], busy_a[d]}), 128'd0);
            chk($sformatf("reset dut%0d data", d), st_rd[d] | 128'(ks_rd[d]) | sb_in_a[d], 128'd0);
        end
        @(posedge clk); #1 resetn = 1'b1;

        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                got = st_r[0] | ks_r[0];
            end
            chk($sformatf("tie%0d grant {st,ks}", k), 128'({st_r[0], ks_r[0]}),
                (k % 2 == 0) ? 128'd2 : 128'd1);
            winner = ks_r[0];
            @(posedge clk);
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                seen = winner ? ks_rv[0] : st_rv[0];
            end
            chk($sformatf("tie%0d rsp seen", k), 128'(seen), 128'd1);
            chk($sformatf("tie%0d rsp data", k), winner ? 128'(ks_rd[0]) : st_rd[0],
                winner ? 128'h16ed7c63 : {16{8'h63}});
        end
        st_v[0] = 1'b0; ks_v[0] = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 6; i++)
                run_job(d, vt[i].ks, vt[i].data, vt[i].exp, $sformatf("L%0d v%0d", lanes_of(d), i));

        // LANES=1 with random state bytes.
        for (int k = 0; k < 16; k++) begin
            rdata[8*k +: 8] = 8'($urandom_range(0, 255));
            rexp[8*k +: 8]  = sbox_f(rdata[8*k +: 8]);
        end
        run_job(1, 1'b0, rdata, rexp, "L1 random");

        // Reset asserted during beat 2 of a state job on the LANES=4 instance.
        @(posedge clk); #1;
        st_v[0] = 1'b1; st_d[0] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        @(negedge clk);
        chk("abort ready", 128'(st_r[0]), 128'd1);
        @(posedge clk); #1 st_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort beat2 sb_in", sb_in_a[0], 128'h0b0a0908);
        #2 resetn = 1'b0;
        #1;
        chk("abort outputs ctl", 128'({st_rv[0], ks_rv[0], sb_en_a[0], busy_a[0]}), 128'd0);
        chk("abort outputs data", st_rd[0] | 128'(ks_rd[0]) | sb_in_a[0], 128'd0);
        @(posedge clk); #1 resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | st_rv[0] | busy_a[0];
        end
        chk("abort no rsp/busy", 128'(seen), 128'd0);
        st_v[0] = 1'b1; ks_v[0] = 1'b1;
        #1;
        chk("post-reset tie {st,ks}", 128'({st_r[0], ks_r[0]}), 128'd2);
        st_v[0] = 1'b0; ks_v[0] = 1'b0;
        @(negedge clk);
        chk("drop without handshake", 128'(busy_a[0]), 128'd0);
        run_job(0, 1'b1, 128'hff530100, 128'h16ed7c63, "post-reset ks");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
